// File: rtl/pendulum_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module     : pendulum_pkg                                        |
// | Description: Shared FSM states and default timing constants.     |
// | Revision   : 1.0 - initial release                               |
// +------------------------------------------------------------------+
package pendulum_pkg;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    WAIT_HALF  = 2'd1,
    WAIT_FULL  = 2'd2
  } meter_state_t;

  localparam int unsigned c_DEBOUNCE_US_DEF = 200;
  localparam int unsigned c_TIMEOUT_US_DEF  = 5000000;

endpackage
`default_nettype wire

// File: rtl/sensor_debounce.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module     : sensor_debounce                                     |
// | Description: Two-flop photogate synchronizer plus time-based     |
// |              debouncer qualified on the microsecond timebase.    |
// | Revision   : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module sensor_debounce
  import pendulum_pkg::*;
#(
  parameter int unsigned DEBOUNCE_US = c_DEBOUNCE_US_DEF
) (
  input  logic        CLK_50,
  input  logic        reset,
  input  logic [31:0] microseconds,
  input  logic        sensor_in,
  output logic        level
);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_level;
  logic        r_pending;
  logic [31:0] r_t_first;
  logic [31:0] w_held;

  // Modulo-2^32 difference keeps qualification correct across timebase wrap.
  assign w_held = microseconds - r_t_first;

  always_ff @(posedge CLK_50) begin
    if (!reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_pending <= 1'b0;
      r_t_first <= '0;
    end else begin
      r_sync1 <= sensor_in;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_pending <= 1'b0;
      end else if (!r_pending) begin
        r_pending <= 1'b1;
        r_t_first <= microseconds;
      end else if (w_held >= 32'(DEBOUNCE_US)) begin
        r_level   <= r_sync2;
        r_pending <= 1'b0;
      end
    end
  end

  assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/pendulum_period_meter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module     : pendulum_period_meter                               |
// | Description: Measures full-swing pendulum period from a photogate|
// |              (two crossings per period), with stall timeout.     |
// |              Define PENDULUM_PERIOD_AVG_EN for a 4-period mean.  |
// | Revision   : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module pendulum_period_meter
  import pendulum_pkg::*;
#(
  parameter int unsigned DEBOUNCE_US = c_DEBOUNCE_US_DEF,
  parameter int unsigned TIMEOUT_US  = c_TIMEOUT_US_DEF
) (
  input  logic        CLK_50,
  input  logic        reset,
  input  logic [31:0] microseconds,
  input  logic        sensor_in,
  output logic        crossing,
  output logic [31:0] period_us,
  output logic        period_valid,
  output logic        timeout
);

  meter_state_t r_state;
  meter_state_t w_state_next;

  logic        w_level;
  logic        r_level_d;
  logic        w_rise;
  logic        r_crossing;
  logic        r_valid;
  logic        r_timeout;
  logic [31:0] r_period;
  logic [31:0] r_t0;
  logic [31:0] r_last_cross;
  logic [31:0] w_period;
  logic [31:0] w_since_cross;
  logic        w_start;
  logic        w_capture;
  logic        w_timeout_hit;

`ifdef PENDULUM_PERIOD_AVG_EN
  logic [31:0] r_hist0;
  logic [31:0] r_hist1;
  logic [31:0] r_hist2;
  logic [1:0]  r_count;
  logic [33:0] w_sum;
  logic [31:0] w_avg;

  assign w_sum = {2'b00, w_period} + {2'b00, r_hist0} + {2'b00, r_hist1} + {2'b00, r_hist2};
  assign w_avg = 32'(w_sum >> 2);
`endif

  sensor_debounce #(
    .DEBOUNCE_US (DEBOUNCE_US)
  ) u_debounce (
    .CLK_50       (CLK_50),
    .reset        (reset),
    .microseconds (microseconds),
    .sensor_in    (sensor_in),
    .level        (w_level)
  );

  assign w_rise        = w_level & ~r_level_d;
  assign w_period      = microseconds - r_t0;
  assign w_since_cross = microseconds - r_last_cross;

  always_ff @(posedge CLK_50) begin
    if (!reset) r_state <= WAIT_FIRST;
    else        r_state <= w_state_next;
  end

  // A crossing always takes precedence over an expiring timeout.
  always_comb begin
    w_state_next  = r_state;
    w_start       = 1'b0;
    w_capture     = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      WAIT_FIRST: begin
        if (w_rise) begin
          w_start      = 1'b1;
          w_state_next = WAIT_HALF;
        end
      end
      WAIT_HALF: begin
        if (w_rise) begin
          w_state_next = WAIT_FULL;
        end else if (w_since_cross > 32'(TIMEOUT_US)) begin
          w_timeout_hit = 1'b1;
          w_state_next  = WAIT_FIRST;
        end
      end
      WAIT_FULL: begin
        if (w_rise) begin
          w_capture    = 1'b1;
          w_state_next = WAIT_HALF;
        end else if (w_since_cross > 32'(TIMEOUT_US)) begin
          w_timeout_hit = 1'b1;
          w_state_next  = WAIT_FIRST;
        end
      end
      default: w_state_next = WAIT_FIRST;
    endcase
  end

  always_ff @(posedge CLK_50) begin
    if (!reset) begin
      r_level_d    <= 1'b0;
      r_crossing   <= 1'b0;
      r_valid      <= 1'b0;
      r_timeout    <= 1'b0;
      r_period     <= '0;
      r_t0         <= '0;
      r_last_cross <= '0;
`ifdef PENDULUM_PERIOD_AVG_EN
      r_hist0      <= '0;
      r_hist1      <= '0;
      r_hist2      <= '0;
      r_count      <= '0;
`endif
    end else begin
      r_level_d  <= w_level;
      r_crossing <= w_rise;
      r_valid    <= 1'b0;
      if (w_rise) begin
        r_last_cross <= microseconds;
        r_timeout    <= 1'b0;
      end else if (w_timeout_hit) begin
        r_timeout <= 1'b1;
      end
      if (w_start || w_capture) r_t0 <= microseconds;
`ifdef PENDULUM_PERIOD_AVG_EN
      // Window restarts after a timeout; output only once four periods exist.
      if (w_timeout_hit) begin
        r_count <= '0;
      end else if (w_capture) begin
        r_hist2 <= r_hist1;
        r_hist1 <= r_hist0;
        r_hist0 <= w_period;
        if (r_count == 2'd3) begin
          r_period <= w_avg;
          r_valid  <= 1'b1;
        end else begin
          r_count <= r_count + 2'd1;
        end
      end
`else
      if (w_capture) begin
        r_period <= w_period;
        r_valid  <= 1'b1;
      end
`endif
    end
  end

  assign crossing     = r_crossing;
  assign period_us    = r_period;
  assign period_valid = r_valid;
  assign timeout      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pendulum_period_meter.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for pendulum_period_meter: directed scenarios plus randomized swings
// checked against an event-level model of crossings and periods.
module tb_pendulum_period_meter;

  localparam int unsigned DEB = 200;
  localparam int unsigned TMO = 5000000;
  localparam int          K   = 4;    // clock cycles per microsecond tick

  logic        CLK_50 = 1'b0;
  logic        reset;
  logic [31:0] microseconds;
  logic        sensor_in;
  logic        crossing;
  logic [31:0] period_us;
  logic        period_valid;
  logic        timeout;

  always #10 CLK_50 = ~CLK_50;

  pendulum_period_meter #(
    .DEBOUNCE_US (DEB),
    .TIMEOUT_US  (TMO)
  ) dut (
    .CLK_50       (CLK_50),
    .reset        (reset),
    .microseconds (microseconds),
    .sensor_in    (sensor_in),
    .crossing     (crossing),
    .period_us    (period_us),
    .period_valid (period_valid),
    .timeout      (timeout)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_cross_seen;
  int          n_valid_seen;
  logic [31:0] last_cross_seen;

  logic [31:0] exp_cross[$];
  logic [31:0] exp_period[$];
  logic [31:0] m_hist[$];
  logic [31:0] m_t0;
  logic [31:0] m_last;
  int          m_phase;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d (0x%08h) expected=%0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic void model_emit(input logic [31:0] p);
`ifdef PENDULUM_PERIOD_AVG_EN
    logic [33:0] s;
    m_hist.push_back(p);
    if (m_hist.size() > 4) void'(m_hist.pop_front());
    if (m_hist.size() == 4) begin
      s = '0;
      foreach (m_hist[i]) s = s + {2'b00, m_hist[i]};
      exp_period.push_back(s[33:2]);
    end
`else
    exp_period.push_back(p);
`endif
  endfunction

  // Two crossings per swing: a period spans every second crossing.
  function automatic void model_cross(input logic [31:0] t);
    exp_cross.push_back(t);
    m_last = t;
    if (m_phase == 0) begin
      m_t0    = t;
      m_phase = 1;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else begin
      model_emit(t - m_t0);
      m_t0    = t;
      m_phase = 1;
    end
  endfunction

  function automatic void model_restart();
    m_phase = 0;
    m_hist.delete();
  endfunction

  task automatic monitor();
    if (crossing) begin
      n_cross_seen++;
      last_cross_seen = microseconds;
      if (exp_cross.size() == 0) check_val("cross_extra", 32'(crossing), 32'd0);
      else check_val("cross_time", microseconds, exp_cross.pop_front());
      check_val("timeout_clr", 32'(timeout), 32'd0);
    end
    if (period_valid) begin
      n_valid_seen++;
      if (exp_period.size() == 0) check_val("valid_extra", 32'(period_valid), 32'd0);
      else check_val("period", period_us, exp_period.pop_front());
    end
  endtask

  task automatic cyc();
    @(negedge CLK_50);
    monitor();
  endtask

  task automatic tick(input logic s);
    for (int i = 0; i < K; i++) begin
      cyc();
      if (i == 0) begin
        microseconds = microseconds + 32'd1;
        sensor_in    = s;
      end
    end
  endtask

  task automatic do_break(input int width, input int half, input bit accepted,
                          output logic [31:0] t_start);
    t_start = microseconds + 32'd1;
    if (accepted) model_cross(t_start + 32'(DEB));
    repeat (width) tick(1'b1);
    repeat (half - width) tick(1'b0);
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    sensor_in    = 1'b0;
    microseconds = '0;
    repeat (3) cyc();
    check_val("rst_crossing", 32'(crossing), 32'd0);
    check_val("rst_valid", 32'(period_valid), 32'd0);
    check_val("rst_period", period_us, 32'd0);
    check_val("rst_timeout", 32'(timeout), 32'd0);
    model_restart();
    exp_cross.delete();
    exp_period.delete();
    n_cross_seen = 0;
    n_valid_seen = 0;
    reset = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t;
    reset        = 1'b0;
    sensor_in    = 1'b0;
    microseconds = '0;

    // Three breaks 500 us apart: one full swing of 1000 us.
    do_reset();
    while (microseconds != 32'd999) tick(1'b0);
    repeat (3) do_break(300, 500, 1'b1, t);
    check_val("s1_crossings", 32'(n_cross_seen), 32'd3);
`ifdef PENDULUM_PERIOD_AVG_EN
    check_val("s1_valids", 32'(n_valid_seen), 32'd0);
`else
    check_val("s1_valids", 32'(n_valid_seen), 32'd1);
    check_val("s1_period", period_us, 32'd1000);
`endif

    // Short glitch rejected; 250 us pulse accepted 200 us after its start.
    do_reset();
    repeat (20) tick(1'b0);
    do_break(150, 450, 1'b0, t);
    check_val("s2_glitch", 32'(n_cross_seen), 32'd0);
    do_break(250, 500, 1'b1, t);
    check_val("s2_pulse", 32'(n_cross_seen), 32'd1);
    check_val("s2_latency", last_cross_seen - t, 32'd200);

    // Period measured across the 32-bit timebase wrap.
    do_reset();
    microseconds = 32'hFFFF_FDFF;
    do_break(300, 1000, 1'b1, t);
    do_break(300, 1000, 1'b1, t);
    do_break(300, 500, 1'b1, t);
`ifndef PENDULUM_PERIOD_AVG_EN
    check_val("s3_wrap_period", period_us, 32'd2000);
`endif

    // Timeout boundary, sticky flag, held period, clean restart.
    do_reset();
    repeat (3) do_break(250, 500, 1'b1, t);
    microseconds = m_last + 32'(TMO);
    repeat (K) cyc();
    check_val("s4_to_edge", 32'(timeout), 32'd0);
    microseconds = m_last + 32'(TMO) + 32'd1;
    repeat (K) cyc();
    check_val("s4_to_set", 32'(timeout), 32'd1);
    model_restart();
    repeat (50) tick(1'b0);
    check_val("s4_to_sticky", 32'(timeout), 32'd1);
`ifndef PENDULUM_PERIOD_AVG_EN
    check_val("s4_period_hold", period_us, 32'd1000);
`endif
    do_break(250, 600, 1'b1, t);
    check_val("s4_to_cleared", 32'(timeout), 32'd0);
    do_break(250, 600, 1'b1, t);
    do_break(250, 500, 1'b1, t);

    // Reset while waiting for the full-swing crossing.
    do_reset();
    repeat (2) do_break(250, 500, 1'b1, t);
    do_reset();
    repeat (3) do_break(250, 600, 1'b1, t);
    check_val("s5_crossings", 32'(n_cross_seen), 32'd3);
`ifndef PENDULUM_PERIOD_AVG_EN
    check_val("s5_period", period_us, 32'd1200);
`endif

`ifdef PENDULUM_PERIOD_AVG_EN
    // Mean of 1000, 1000, 1000, 1004 truncates to 1001.
    do_reset();
    repeat (6) do_break(250, 500, 1'b1, t);
    repeat (2) do_break(250, 502, 1'b1, t);
    check_val("s6_no_early_valid", 32'(n_valid_seen), 32'd0);
    do_break(250, 400, 1'b1, t);
    check_val("s6_valids", 32'(n_valid_seen), 32'd1);
    check_val("s6_avg", period_us, 32'd1001);
`endif

    // Randomized swings with interleaved glitches at a random timebase origin.
    do_reset();
    microseconds = $urandom();
    for (int i = 0; i < 7; i++) begin
      int half;
      int width;
      int gw;
      if ($urandom_range(1, 0) == 1) begin
        gw = $urandom_range(180, 20);
        do_break(gw, gw + 250, 1'b0, t);
      end
      half  = $urandom_range(750, 450);
      width = $urandom_range(half - 220, 210);
      do_break(width, half, 1'b1, t);
    end

    check_val("cross_pending", 32'(exp_cross.size()), 32'd0);
    check_val("period_pending", 32'(exp_period.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
